branch_ctrl: RTL and testbench

- Branch resolution and redirect controller for the rv32 core's EX stage.
- Takes the branch-condition result, the front end's prediction and the instruction operands, and decides whether the prediction was wrong.
- On a mispredict it sequences the fetch redirect handshake and the IF/ID flush.
- Also issues predictor-update pulses and keeps resolution and mispredict statistics.

---
 rtl/branch_ctrl.sv | 157 +++++++++++++++
 tb/tb_branch_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution and redirect controller for the EX stage: resolves control flow,
// detects mispredicts, sequences the fetch redirect and IF/ID flush, and keeps statistics.
module branch_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [2:0]       ex_func3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1_val,
    input  logic             br_confirm,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             flush_if,
    output logic             flush_id,
    output logic             stall_ex,
    output logic             bp_upd_valid,
    output logic [31:0]      bp_upd_pc,
    output logic             bp_upd_taken,
    output logic [31:0]      bp_upd_target,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [31:0]       redir_pc_q, redir_pc_d;
    logic              bp_upd_valid_q, bp_upd_valid_d;
    logic [31:0]       bp_upd_pc_q, bp_upd_pc_d;
    logic              bp_upd_taken_q, bp_upd_taken_d;
    logic [31:0]       bp_upd_target_q, bp_upd_target_d;
    logic [CNT_W-1:0]  resolved_cnt_q, resolved_cnt_d;
    logic [CNT_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    logic        is_branch, is_jal, is_jalr, is_cf;
    logic        act_taken, mispredict, resolve;
    logic [31:0] act_target, next_pc;

    // func3 010/011 are not defined branch conditions and resolve as not-taken
    always_comb begin
        is_branch  = (ex_opcode == OP_BRANCH);
        is_jal     = (ex_opcode == OP_JAL);
        is_jalr    = (ex_opcode == OP_JALR);
        is_cf      = is_branch || is_jal || is_jalr;
        act_taken  = is_branch ? (br_confirm && (ex_func3 != 3'b010) && (ex_func3 != 3'b011))
                               : (is_jal || is_jalr);
        act_target = is_jalr ? ((ex_rs1_val + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
        next_pc    = act_taken ? act_target : (ex_pc + 32'd4);
        mispredict = (ex_pred_taken != act_taken) ||
                     (act_taken && ex_pred_taken && (ex_pred_target != act_target));
        resolve    = (state_q == IDLE) && ex_valid && is_cf;
    end

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redir_pc_d       = redir_pc_q;
        bp_upd_valid_d   = 1'b0;
        bp_upd_pc_d      = bp_upd_pc_q;
        bp_upd_taken_d   = bp_upd_taken_q;
        bp_upd_target_d  = bp_upd_target_q;
        resolved_cnt_d   = resolved_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;

        case (state_q)
            IDLE: begin
                if (resolve) begin
                    bp_upd_valid_d  = 1'b1;
                    bp_upd_pc_d     = ex_pc;
                    bp_upd_taken_d  = act_taken;
                    bp_upd_target_d = act_target;
                    if (resolved_cnt_q != '1)
                        resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
                    if (mispredict) begin
                        if (mispredict_cnt_q != '1)
                            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
                        redir_pc_d = next_pc;
                        state_d    = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FC_W'(FLUSH_CYCLES);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q <= FC_W'(1))
                    state_d = IDLE;
                else
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            redir_pc_q       <= '0;
            bp_upd_valid_q   <= 1'b0;
            bp_upd_pc_q      <= '0;
            bp_upd_taken_q   <= 1'b0;
            bp_upd_target_q  <= '0;
            resolved_cnt_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            redir_pc_q       <= redir_pc_d;
            bp_upd_valid_q   <= bp_upd_valid_d;
            bp_upd_pc_q      <= bp_upd_pc_d;
            bp_upd_taken_q   <= bp_upd_taken_d;
            bp_upd_target_q  <= bp_upd_target_d;
            resolved_cnt_q   <= resolved_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redir_valid    = (state_q == REDIRECT);
    assign stall_ex       = (state_q == REDIRECT);
    assign flush_if       = (state_q != IDLE);
    assign flush_id       = (state_q != IDLE);
    assign redir_pc       = redir_pc_q;
    assign bp_upd_valid   = bp_upd_valid_q;
    assign bp_upd_pc      = bp_upd_pc_q;
    assign bp_upd_taken   = bp_upd_taken_q;
    assign bp_upd_target  = bp_upd_target_q;
    assign resolved_cnt   = resolved_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios then randomized traffic, all checked against
// a behavioural model of resolution, redirect/flush timing and the statistics counters.
module tb_branch_ctrl;

    localparam int FC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_pred_target;
    logic        br_confirm, ex_pred_taken, redir_ready;

    logic        redir_valid, flush_if, flush_id, stall_ex, bp_upd_valid, bp_upd_taken;
    logic [31:0] redir_pc, bp_upd_pc, bp_upd_target;
    logic [15:0] resolved_cnt, mispredict_cnt;

    // second build: no extra flush cycles and narrow counters to reach saturation quickly
    logic        z_redir_valid, z_flush_if, z_flush_id, z_stall_ex, z_bp_upd_valid, z_bp_upd_taken;
    logic [31:0] z_redir_pc, z_bp_upd_pc, z_bp_upd_target;
    logic [3:0]  z_resolved_cnt, z_mispredict_cnt;

    int tests    = 0;
    int failures = 0;

    int          m_mode;
    int          m_left;
    logic [31:0] m_redir_pc;
    logic        m_bp_valid;
    logic [31:0] m_bp_pc, m_bp_target;
    logic        m_bp_taken;
    int          m_res, m_mis;

    always #5 clk = ~clk;

    branch_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_func3(ex_func3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
        .br_confirm(br_confirm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
        .bp_upd_target(bp_upd_target), .resolved_cnt(resolved_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) dut_z (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_func3(ex_func3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
        .br_confirm(br_confirm), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redir_valid(z_redir_valid), .redir_pc(z_redir_pc), .redir_ready(redir_ready),
        .flush_if(z_flush_if), .flush_id(z_flush_id), .stall_ex(z_stall_ex),
        .bp_upd_valid(z_bp_upd_valid), .bp_upd_pc(z_bp_upd_pc), .bp_upd_taken(z_bp_upd_taken),
        .bp_upd_target(z_bp_upd_target), .resolved_cnt(z_resolved_cnt),
        .mispredict_cnt(z_mispredict_cnt)
    );

    function automatic void ref_resolve(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [31:0] pc, input logic [31:0] imm,
                                        input logic [31:0] rs1, input logic conf,
                                        output logic cf, output logic taken,
                                        output logic [31:0] target, output logic [31:0] npc);
        cf = 1'b1;
        taken = 1'b1;
        target = pc + imm;
        if (op == 7'h63)
            taken = conf && (f3 != 3'd2) && (f3 != 3'd3);
        else if (op == 7'h67)
            target = (rs1 + imm) & 32'hFFFF_FFFE;
        else if (op != 7'h6F)
            cf = 1'b0;
        npc = taken ? target : pc + 32'd4;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic conf, input logic pt,
                                 input logic [31:0] ptgt, input logic rdy);
        ex_valid = v; ex_opcode = op; ex_func3 = f3; ex_pc = pc; ex_imm = imm;
        ex_rs1_val = rs1; br_confirm = conf; ex_pred_taken = pt; ex_pred_target = ptgt;
        redir_ready = rdy;
    endtask

    task automatic modelReset();
        m_mode = 0; m_left = 0; m_redir_pc = '0; m_bp_valid = 1'b0;
        m_bp_pc = '0; m_bp_target = '0; m_bp_taken = 1'b0; m_res = 0; m_mis = 0;
    endtask

    // mode 0 = idle, 1 = waiting for fetch to accept the redirect, 2 = trailing flush
    task automatic modelEdge();
        logic cf, taken;
        logic [31:0] tgt, npc;
        m_bp_valid = 1'b0;
        if (m_mode == 0) begin
            ref_resolve(ex_opcode, ex_func3, ex_pc, ex_imm, ex_rs1_val, br_confirm,
                        cf, taken, tgt, npc);
            if (ex_valid && cf) begin
                m_bp_valid = 1'b1; m_bp_pc = ex_pc; m_bp_taken = taken; m_bp_target = tgt;
                if (m_res < 65535) m_res++;
                if (ex_pred_taken != taken || (taken && ex_pred_target != tgt)) begin
                    if (m_mis < 65535) m_mis++;
                    m_redir_pc = npc;
                    m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (redir_ready) begin
                m_mode = (FC > 0) ? 2 : 0;
                m_left = FC;
            end
        end else begin
            if (m_left == 1) m_mode = 0;
            else m_left--;
        end
    endtask

    task automatic checkAll();
        checkOutput("redir_valid", 32'(redir_valid), 32'(m_mode == 1));
        checkOutput("stall_ex", 32'(stall_ex), 32'(m_mode == 1));
        checkOutput("flush_if", 32'(flush_if), 32'(m_mode != 0));
        checkOutput("flush_id", 32'(flush_id), 32'(m_mode != 0));
        checkOutput("bp_upd_valid", 32'(bp_upd_valid), 32'(m_bp_valid));
        checkOutput("resolved_cnt", 32'(resolved_cnt), 32'(m_res));
        checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
        if (m_mode == 1)
            checkOutput("redir_pc", redir_pc, m_redir_pc);
        if (m_bp_valid) begin
            checkOutput("bp_upd_pc", bp_upd_pc, m_bp_pc);
            checkOutput("bp_upd_taken", 32'(bp_upd_taken), 32'(m_bp_taken));
            checkOutput("bp_upd_target", bp_upd_target, m_bp_target);
        end
    endtask

    task automatic step();
        modelEdge();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        logic [6:0]  op;
        logic [31:0] pc, imm, rs1, ptgt, tgt, npc;
        logic        cf, taken;

        rst_n = 1'b0;
        applyStimulus(0, 7'h00, 3'd0, '0, '0, '0, 0, 0, '0, 0);
        modelReset();
        #12;
        checkAll();
        checkOutput("reset redir_pc", redir_pc, 32'h0);
        checkOutput("reset z_resolved_cnt", 32'(z_resolved_cnt), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // correctly predicted taken beq
        applyStimulus(1, 7'h63, 3'b000, 32'h100, 32'h20, '0, 1, 1, 32'h120, 0);
        step();
        checkOutput("beq target", bp_upd_target, 32'h120);

        // not-taken bne predicted taken, fetch stalls three cycles before accepting
        applyStimulus(1, 7'h63, 3'b001, 32'h200, 32'h40, '0, 0, 1, 32'h240, 0);
        step();
        checkOutput("bne redir_pc", redir_pc, 32'h204);
        applyStimulus(0, 7'h00, 3'd0, '0, '0, '0, 0, 0, '0, 0);
        repeat (3) step();
        redir_ready = 1'b1;
        step();
        redir_ready = 1'b0;
        step();
        checkOutput("bne mispredict_cnt", 32'(mispredict_cnt), 32'd1);

        // jalr with low bit cleared, first correct then wrong target
        applyStimulus(1, 7'h67, 3'b000, 32'h300, 32'h4, 32'h1003, 0, 1, 32'h1006, 0);
        step();
        ex_pred_target = 32'h1008;
        step();
        checkOutput("jalr redir_pc", redir_pc, 32'h1006);

        // wrong-path jal offered during redirect must be ignored
        applyStimulus(1, 7'h6F, 3'b000, 32'h400, 32'h10, '0, 0, 0, '0, 0);
        repeat (2) step();
        applyStimulus(0, 7'h00, 3'd0, '0, '0, '0, 0, 0, '0, 1);
        step();
        redir_ready = 1'b0;
        step();

        // undefined func3 branch resolves not-taken; ready while idle has no effect
        applyStimulus(1, 7'h63, 3'b010, 32'h500, 32'h80, '0, 1, 0, '0, 1);
        step();
        checkOutput("func3 010 taken", 32'(bp_upd_taken), 32'h0);

        // asynchronous reset while a redirect is pending
        applyStimulus(1, 7'h6F, 3'b000, 32'h600, 32'h100, '0, 0, 0, '0, 0);
        step();
        ex_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("async redir_pc", redir_pc, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // back-to-back correct jals; narrow counters saturate at 15
        for (int k = 0; k < 20; k++) begin
            pc = 32'h1000 + 32'(k * 8);
            applyStimulus(1, 7'h6F, 3'b000, pc, 32'h40, '0, 0, 1, pc + 32'h40, 0);
            step();
            checkOutput("z_resolved_cnt sat", 32'(z_resolved_cnt), (k >= 14) ? 32'd15 : 32'(k + 1));
        end

        // zero-flush build returns to idle straight after the handshake
        applyStimulus(1, 7'h6F, 3'b000, 32'h2000, 32'h8, '0, 0, 0, '0, 0);
        step();
        checkOutput("z_redir_valid", 32'(z_redir_valid), 32'h1);
        applyStimulus(0, 7'h00, 3'd0, '0, '0, '0, 0, 0, '0, 1);
        step();
        checkOutput("z_flush_if after hs", 32'(z_flush_if), 32'h0);
        checkOutput("z_redir_valid after hs", 32'(z_redir_valid), 32'h0);
        redir_ready = 1'b0;
        step();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: op = 7'h63;
                1: op = 7'h6F;
                2: op = 7'h67;
                default: op = 7'($urandom);
            endcase
            pc  = $urandom & 32'hFFFF_FFFC;
            imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            rs1 = $urandom;
            ref_resolve(op, 3'($urandom), pc, imm, rs1, 1'b1, cf, taken, tgt, npc);
            ptgt = ($urandom_range(0, 1) == 1) ? tgt : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, op, 3'($urandom), pc, imm, rs1,
                          1'($urandom), 1'($urandom), ptgt, $urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
